// File: rtl/cfg_req_fifo_reader.sv
// Config-domain consumer of the IOSF-to-config request FIFO: pops one request word, performs a
// single register access with req/ack handshake and timeout, then pushes the completion word.
module cfg_req_fifo_reader #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [143:0]   req_q,
    input  logic           req_rdempty,
    output logic           req_rdreq,
    output logic           cfg_req,
    output logic           cfg_wr,
    output logic [31:0]    cfg_addr,
    output logic [31:0]    cfg_wdata,
    output logic [3:0]     cfg_be,
    input  logic           cfg_ack,
    input  logic [31:0]    cfg_rdata,
    output logic [143:0]   cpl_data,
    output logic           cpl_wrreq,
    input  logic           cpl_wrfull,
    output logic           busy,
    output logic [15:0]    timeout_cnt
);

    typedef enum logic [2:0] {
        st_idle,
        st_pop,
        st_latch,
        st_req,
        st_cpl
    } state_t;

    localparam logic [15:0] tmo_last = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    logic [15:0] tcnt;
    logic [7:0]  tag;

    // Reserved request bits carry no meaning for this block.
    logic unused_req_bits;
    assign unused_req_bits = ^{req_q[130:128], req_q[95:32]};

    assign cpl_wrreq = (state == st_cpl) & ~cpl_wrfull;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= st_idle;
            tcnt        <= 16'h0;
            tag         <= 8'h0;
            req_rdreq   <= 1'b0;
            cfg_req     <= 1'b0;
            cfg_wr      <= 1'b0;
            cfg_addr    <= 32'h0;
            cfg_wdata   <= 32'h0;
            cfg_be      <= 4'h0;
            cpl_data    <= 144'h0;
            busy        <= 1'b0;
            timeout_cnt <= 16'h0;
        end else begin
            case (state)
                st_idle: begin
                    if (!req_rdempty && !cpl_wrfull) begin
                        state     <= st_pop;
                        req_rdreq <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                st_pop: begin
                    state     <= st_latch;
                    req_rdreq <= 1'b0;
                end
                st_latch: begin
                    tag       <= req_q[143:136];
                    cfg_wr    <= req_q[135];
                    cfg_be    <= req_q[134:131];
                    cfg_addr  <= req_q[127:96];
                    cfg_wdata <= req_q[31:0];
                    tcnt      <= 16'h0;
                    cfg_req   <= 1'b1;
                    state     <= st_req;
                end
                st_req: begin
                    tcnt <= tcnt + 16'h1;
                    // An ack on the final allowed cycle still counts as success.
                    if (cfg_ack) begin
                        cpl_data <= {tag, cfg_wr, 2'b00, 101'h0, (cfg_wr ? 32'h0 : cfg_rdata)};
                        cfg_req  <= 1'b0;
                        state    <= st_cpl;
                    end else if (tcnt == tmo_last) begin
                        cpl_data <= {tag, cfg_wr, 2'b01, 101'h0, 32'h0};
                        cfg_req  <= 1'b0;
                        state    <= st_cpl;
                        if (timeout_cnt != 16'hFFFF) begin
                            timeout_cnt <= timeout_cnt + 16'h1;
                        end
                    end
                end
                st_cpl: begin
                    if (!cpl_wrfull) begin
                        state <= st_idle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= st_idle;
                    req_rdreq <= 1'b0;
                    cfg_req   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_req_fifo_reader.sv
// Scoreboard bench for cfg_req_fifo_reader: FIFO and register-file models, directed requests,
// expected accesses and completions queued at issue time and checked by independent monitors.
module tb_cfg_req_fifo_reader;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [143:0]   req_q = '0;
    logic           req_rdempty;
    logic           req_rdreq;
    logic           cfg_req;
    logic           cfg_wr;
    logic [31:0]    cfg_addr;
    logic [31:0]    cfg_wdata;
    logic [3:0]     cfg_be;
    logic           cfg_ack = 1'b0;
    logic [31:0]    cfg_rdata;
    logic [143:0]   cpl_data;
    logic           cpl_wrreq;
    logic           cpl_wrfull;
    logic           busy;
    logic [15:0]    timeout_cnt;

    always #5 clk = ~clk;

    cfg_req_fifo_reader #(.TIMEOUT_CYC(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_q       (req_q),
        .req_rdempty (req_rdempty),
        .req_rdreq   (req_rdreq),
        .cfg_req     (cfg_req),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_be      (cfg_be),
        .cfg_ack     (cfg_ack),
        .cfg_rdata   (cfg_rdata),
        .cpl_data    (cpl_data),
        .cpl_wrreq   (cpl_wrreq),
        .cpl_wrfull  (cpl_wrfull),
        .busy        (busy),
        .timeout_cnt (timeout_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [143:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign req_rdempty = (wr_ptr == rd_ptr);

    logic [143:0] exp_cpl[$];
    logic [143:0] exp_acc[$];

    int ack_after = 0;
    logic [31:0] rd_val = 32'h0;
    assign cfg_rdata = rd_val;

    int pop_count = 0, cpl_count = 0;
    int last_cpl_cyc = 0, last_pop_cyc = 0, pop_gap = 0;
    int rise_cyc = 0, ack_cyc = 0, rq_len = 0, last_len = 0;
    int first_pop_cyc = 0;
    bit arm_first = 0;

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [143:0] mk_req(input logic [7:0] tag, input logic wr,
                                            input logic [3:0] be, input logic [31:0] addr,
                                            input logic [31:0] wdata);
        logic [143:0] w;
        w = '0;
        w[143:136] = tag;
        w[135] = wr;
        w[134:131] = be;
        w[130:128] = 3'b111;
        w[127:96] = addr;
        w[95:32] = 64'hA5A5_5A5A_F00D_CAFE;
        w[31:0] = wdata;
        return w;
    endfunction

    function automatic logic [143:0] mk_cpl(input logic [7:0] tag, input logic wr,
                                            input logic [1:0] st, input logic [31:0] rdata);
        logic [143:0] w;
        w = '0;
        w[143:136] = tag;
        w[135] = wr;
        w[134:133] = st;
        w[31:0] = rdata;
        return w;
    endfunction

    task automatic push(input logic [7:0] tag, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit want_cpl,
                        input logic [1:0] st, input logic [31:0] rdata);
        mem[wr_ptr] = mk_req(tag, wr, be, addr, wdata);
        wr_ptr++;
        exp_acc.push_back({75'h0, wr, be, addr, wdata});
        if (want_cpl) exp_cpl.push_back(mk_cpl(tag, wr, st, rdata));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_cpl.size() != 0 || busy || wr_ptr != rd_ptr) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_bound"}, 144'(n >= 400), 144'h0);
        check({name, "_acc_left"}, 144'(exp_acc.size()), 144'h0);
    endtask

    // Request FIFO model (normal mode): data appears after the pop.
    initial forever begin
        @(negedge clk);
        if (req_rdreq) begin
            check("rdreq_while_empty", 144'(req_rdempty), 144'h0);
            if (rd_ptr != wr_ptr) begin
                req_q = mem[rd_ptr];
                rd_ptr++;
            end
            pop_count++;
            pop_gap = cyc - last_cpl_cyc;
            last_pop_cyc = cyc;
            if (arm_first) begin
                first_pop_cyc = cyc;
                arm_first = 0;
            end
        end
    end

    // Register file model: acks on the (ack_after+1)-th cycle of cfg_req; -1 never acks.
    initial forever begin
        @(negedge clk);
        if (cfg_req) begin
            rq_len++;
            if (rq_len == 1) begin
                rise_cyc = cyc;
                if (exp_acc.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL acc_unexpected: got addr %0h", cfg_addr);
                end else begin
                    check("acc_fields", {75'h0, cfg_wr, cfg_be, cfg_addr, cfg_wdata},
                          exp_acc.pop_front());
                end
            end
            if (ack_after >= 0 && rq_len == ack_after + 1) begin
                cfg_ack = 1'b1;
                ack_cyc = cyc;
            end else begin
                cfg_ack = 1'b0;
            end
        end else begin
            if (rq_len != 0) last_len = rq_len;
            rq_len = 0;
            cfg_ack = 1'b0;
        end
    end

    // Completion monitor.
    initial forever begin
        @(negedge clk);
        if (cpl_wrreq) begin
            check("cpl_while_full", 144'(cpl_wrfull), 144'h0);
            cpl_count++;
            last_cpl_cyc = cyc;
            if (exp_cpl.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL cpl_unexpected: got %0h expected none", cpl_data);
            end else begin
                check("cpl_data", cpl_data, exp_cpl.pop_front());
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        int p0, c0, n;
        rst_n = 1'b0;
        cpl_wrfull = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {req_rdreq, cfg_req, cfg_wr, cpl_wrreq, busy, cfg_be,
                                cfg_addr, cfg_wdata, timeout_cnt}, 144'h0);
        check("reset_cpl_data", cpl_data, 144'h0);
        rst_n = 1'b1;

        // Single read, ack two cycles after cfg_req.
        @(posedge clk); #1;
        ack_after = 2;
        rd_val = 32'hDEAD_BEEF;
        p0 = pop_count;
        push(8'h5A, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 1, 2'b00, 32'hDEAD_BEEF);
        wait_done("read");
        check("read_pops", 144'(pop_count), 144'(p0 + 1));
        check("read_req_latency", 144'(rise_cyc), 144'(last_pop_cyc + 2));
        check("read_ack_cyc", 144'(ack_cyc), 144'(rise_cyc + 2));
        check("read_cpl_latency", 144'(last_cpl_cyc), 144'(ack_cyc + 1));

        // Write: rdata must be zero even though the register file drives data.
        ack_after = 1;
        rd_val = 32'hFFFF_FFFF;
        push(8'h01, 1'b1, 4'h3, 32'h40, 32'h1234_5678, 1, 2'b00, 32'h0);
        wait_done("write");
        check("write_fields_stable", {cfg_wr, cfg_be, cfg_wdata}, {1'b1, 4'h3, 32'h1234_5678});

        // Timeout with no ack, then ack on the last allowed cycle.
        ack_after = -1;
        push(8'h77, 1'b0, 4'hF, 32'h100, 32'h0, 1, 2'b01, 32'h0);
        wait_done("tmo");
        check("tmo_req_len", 144'(last_len), 144'd8);
        check("tmo_count", 144'(timeout_cnt), 144'd1);
        ack_after = 7;
        rd_val = 32'hCAFE_F00D;
        push(8'h78, 1'b0, 4'hF, 32'h104, 32'h0, 1, 2'b00, 32'hCAFE_F00D);
        wait_done("ack_last");
        check("ack_last_req_len", 144'(last_len), 144'd8);
        check("ack_last_count", 144'(timeout_cnt), 144'd1);

        // Completion back-pressure in CPL.
        ack_after = 0;
        rd_val = 32'h1111_2222;
        push(8'h20, 1'b0, 4'hF, 32'h200, 32'h0, 1, 2'b00, 32'h1111_2222);
        push(8'h21, 1'b1, 4'h1, 32'h204, 32'h9, 1, 2'b00, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cfg_req && n < 50);
        check("bp_req_bound", 144'(n >= 50), 144'h0);
        @(posedge clk); #1;
        cpl_wrfull = 1'b1;
        p0 = pop_count;
        c0 = cpl_count;
        repeat (10) @(posedge clk);
        #1;
        check("bp_no_pop", 144'(pop_count), 144'(p0));
        check("bp_no_cpl", 144'(cpl_count), 144'(c0));
        check("bp_busy", 144'(busy), 144'h1);
        cpl_wrfull = 1'b0;
        wait_done("bp");
        check("bp_pop_after_cpl", 144'(pop_gap), 144'd2);

        // Full completion FIFO while idle blocks the pop.
        @(posedge clk); #1;
        cpl_wrfull = 1'b1;
        p0 = pop_count;
        push(8'h30, 1'b0, 4'hF, 32'h300, 32'h0, 1, 2'b00, 32'h1111_2222);
        repeat (10) @(posedge clk);
        #1;
        check("idle_full_no_pop", 144'(pop_count), 144'(p0));
        check("idle_full_busy", 144'(busy), 144'h0);
        cpl_wrfull = 1'b0;
        wait_done("idle_full");

        // Back-to-back burst of 16 with zero-wait ack.
        @(posedge clk); #1;
        rd_val = 32'h0BAD_F00D;
        p0 = pop_count;
        arm_first = 1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] t;
            t = 8'(i);
            push(t, t[0], t[3:0], 32'(i * 4), 32'(i) * 32'h0101_0101, 1, 2'b00,
                 t[0] ? 32'h0 : 32'h0BAD_F00D);
        end
        wait_done("b2b");
        check("b2b_pops", 144'(pop_count), 144'(p0 + 16));
        check("b2b_span", 144'(last_cpl_cyc - first_pop_cyc), 144'd78);
        check("b2b_busy_end", 144'(busy), 144'h0);

        // Reset while cfg_req is high: request lost, next one processed.
        ack_after = -1;
        push(8'h90, 1'b0, 4'hF, 32'h400, 32'h0, 0, 2'b00, 32'h0);
        push(8'h91, 1'b1, 4'hF, 32'h404, 32'h55AA_55AA, 1, 2'b00, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cfg_req && n < 50);
        check("rst_req_bound", 144'(n >= 50), 144'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_req", {cfg_req, busy, cpl_wrreq, timeout_cnt}, 144'h0);
        ack_after = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_done("rst_next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cfg_req_fifo_reader.md
# cfg_req_fifo_reader

Config-domain consumer of the IOSF-to-config request FIFO. It pops one 144-bit request word at a time and decodes it into a single config-register access with a req/ack handshake. It then packs the result into a 144-bit completion word and pushes it into the config-to-IOSF completion FIFO. The block sits entirely in the FIFO read-clock (config) domain, between the request FIFO's read port, the config register file and the completion FIFO's write port.

## Interface
Parameters:
- TIMEOUT_CYC, 1024: cycles `cfg_req` may stay high without `cfg_ack` before the access is aborted. Legal range 2..65535.

Ports:
- clk  in  1  config-domain clock; same clock as the request FIFO rdclk and the completion FIFO wrclk.
- rst_n  in  1  asynchronous, active-low reset.
- req_q  in  144  request FIFO dataout; normal (non-show-ahead) mode, valid the cycle after `req_rdreq`.
- req_rdempty  in  1  request FIFO empty.
- req_rdreq  out  1  request FIFO pop, one-cycle pulse.
- cfg_req  out  1  register access request; held until ack or timeout.
- cfg_wr  out  1  1 = write, 0 = read.
- cfg_addr  out  32  register byte address.
- cfg_wdata  out  32  write data.
- cfg_be  out  4  byte enables.
- cfg_ack  in  1  access done; sampled only while `cfg_req` = 1.
- cfg_rdata  in  32  read data, valid with `cfg_ack`.
- cpl_data  out  144  completion FIFO datain.
- cpl_wrreq  out  1  completion FIFO write.
- cpl_wrfull  in  1  completion FIFO full.
- busy  out  1  1 whenever state ≠ IDLE.
- timeout_cnt  out  16  saturating count of timed-out accesses.

## Operation
- Request word fields:
  - [143:136] tag
  - [135] wr
  - [134:131] be
  - [127:96] addr
  - [31:0] wdata
  - all other bits are ignored.
- Completion word fields:
  - [143:136] tag
  - [135] wr
  - [134:133] status: 00 = success, 01 = unsupported/timeout
  - [31:0] rdata: `cfg_rdata` for a successful read; 0 for writes and timeouts
  - all other bits are 0.
- State machine and transitions:
  - IDLE: if `!req_rdempty && !cpl_wrfull`, go to POP.
  - POP: `req_rdreq` = 1 for exactly this cycle; go to LATCH.
  - LATCH: capture `req_q` fields into the `cfg_*` output registers; go to REQ.
  - REQ: `cfg_req` = 1 and the timeout counter increments.
    - `cfg_ack` = 1: capture `cfg_rdata`, status 00; go to CPL.
    - Counter reaches TIMEOUT_CYC−1 with no ack: status 01, rdata 0, `timeout_cnt` += 1 (saturates at 0xFFFF); go to CPL.
    - `cfg_ack` and timeout in the same cycle: ack wins.
  - CPL: `cpl_wrreq` = (state==CPL) & `!cpl_wrfull` (combinational). Return to IDLE on the cycle the write happens; stay in CPL while the FIFO is full.
- Only one access is outstanding at a time; the next pop happens no earlier than the cycle after the completion write.
- `cfg_ack` outside REQ is ignored.
- `cfg_addr`, `cfg_wdata`, `cfg_be` and `cfg_wr` are stable from LATCH until the next LATCH.
- The timeout counter clears on entry to REQ.

## Timing
- Reset values:
  - state IDLE
  - `req_rdreq`, `cfg_req`, `cfg_wr`, `cpl_wrreq`, `busy` = 0
  - `cfg_addr`, `cfg_wdata`, `cfg_be` = 0
  - `cpl_data` = 0
  - `timeout_cnt` = 0
- Reset mid-operation returns to IDLE immediately and drops `cfg_req`. The in-flight request is lost and no completion is produced.
- Latency, with empty deasserted at cycle N:
  - `req_rdreq` high at N+1.
  - `cfg_req` high at N+3.
  - `cfg_ack` at cycle A → `cfg_req` low and `cpl_wrreq` high at A+1 (if not full).
  - Minimum request-to-completion is 4 cycles plus register latency.
- Throughput: at most one request per 5 cycles with zero-wait ack.
- Timeout: `cfg_req` is high for exactly TIMEOUT_CYC cycles, then the block enters CPL.
- `req_rdreq` is never asserted while `req_rdempty` = 1. `cpl_wrreq` is never asserted while `cpl_wrfull` = 1.

## Test plan
- Single read: push {tag=0x5A, wr=0, be=0xF, addr=0x0000_0010}; register file acks 2 cycles after `cfg_req` with rdata 0xDEAD_BEEF → completion [143:136]=0x5A, [135]=0, status 00, [31:0]=0xDEAD_BEEF; exactly one `req_rdreq` pulse.
- Write: push {tag=0x01, wr=1, be=0x3, addr=0x40, wdata=0x1234_5678} → `cfg_wr`=1, `cfg_be`=0x3, `cfg_wdata`=0x1234_5678; completion status 00, rdata 0.
- Timeout: TIMEOUT_CYC=8, never ack → `cfg_req` high exactly 8 cycles; completion status 01, rdata 0; `timeout_cnt`=1. Repeat with ack in cycle 8 → status 00 and `timeout_cnt` unchanged.
- Back-pressure: hold `cpl_wrfull`=1 during CPL for 10 cycles → no `cpl_wrreq` and no new pop; release → one write, then the next pop. Hold `cpl_wrfull`=1 in IDLE with a non-empty FIFO → no `req_rdreq`.
- Back-to-back: 16 requests with tags 0..15, zero-wait ack → 16 completions in tag order, no `req_rdreq` while empty, `busy` low at the end.
- Reset mid-REQ: deassert `rst_n` while `cfg_req`=1 → `cfg_req` low asynchronously, no completion written; after release the next queued request is processed normally.
